// File: rtl/testrig_dii_instr_feeder.sv
// ----------------------------------------------------------------------------
// testrig_dii_instr_feeder
//
// Instruction source placed in front of the Ibex TestRIG wrapper's fetch port.
// Words arriving on the DII stream are buffered in a small FIFO. Each granted
// core fetch pops one word, whatever the fetch address. The word comes back on
// the rvalid/rdata bus a fixed number of cycles after the grant. A running
// count of counted fetch responses is exported so the harness can line up
// RVFI traces with the injected stream.
//
// Parameters
//   FifoDepth       DII buffer entries (power of two, >= 2)
//   RespLatency     cycles from grant to rvalid (1..4)
//   MaxOutstanding  limit on granted-but-not-yet-answered fetches (>= 1)
//
// Ports
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   flush_i             synchronous clear of buffered, not yet granted words
//   dii_valid_i         injected instruction valid
//   dii_insn_i  [31:0]  injected instruction word
//   dii_ready_o         buffer can accept dii_insn_i this cycle
//   instr_req_i         core fetch request
//   instr_addr_i[31:0]  core fetch address (unused, debug visibility only)
//   instr_gnt_o         fetch granted
//   instr_rvalid_o      fetch response valid
//   instr_rdata_o[31:0] fetch response data (holds its value between responses)
//   instr_rdata_intg_o  7-bit inverted SECDED(39,32) check bits of instr_rdata_o
//   instr_err_o         fetch bus error, always 0
//   resp_count_o[31:0]  counted rvalid pulses since reset/flush, wraps
// ----------------------------------------------------------------------------
module testrig_dii_instr_feeder #(
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        dii_valid_i,
  input  logic [31:0] dii_insn_i,
  output logic        dii_ready_o,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  output logic [31:0] resp_count_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  // Inverted Hsiao SECDED(39,32) check bits, matching the encoder Ibex uses
  // on its instruction bus.
  function automatic logic [6:0] secded_inv_39_32_intg(input logic [31:0] data);
    logic [6:0] parity;
    parity[0] = ^(data & 32'h2606BD25);
    parity[1] = ^(data & 32'hDEBA8050);
    parity[2] = ^(data & 32'h413D89AA);
    parity[3] = ^(data & 32'h31234ED1);
    parity[4] = ^(data & 32'hC2C1323B);
    parity[5] = ^(data & 32'h2DCC624C);
    parity[6] = ^(data & 32'h98505586);
    return parity ^ 7'h2A;
  endfunction

  // --------------------------------------------------------------------------
  // DII instruction FIFO
  // --------------------------------------------------------------------------
  logic [31:0]     fifo_mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [31:0]     fifo_head;

  assign fifo_full  = (fifo_cnt_q == CntW'(FifoDepth));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // Ready is purely a function of stored occupancy: a pop in the same cycle
  // does not make room for a push.
  assign dii_ready_o = !fifo_full;

  // A word offered during a flush is dropped along with the buffer contents.
  assign fifo_push = dii_valid_i && dii_ready_o && !flush_i;
  assign fifo_pop  = instr_gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (fifo_push && !fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      end else if (!fifo_push && fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= dii_insn_i;
    end
  end

  // --------------------------------------------------------------------------
  // Grant and outstanding tracking
  // --------------------------------------------------------------------------
  logic [OutW-1:0] outstanding_q;
  logic [OutW-1:0] outstanding_eff;

  // A response leaving this cycle frees its slot for a grant in the same
  // cycle, so the limit is checked against the post-response occupancy.
  assign outstanding_eff = outstanding_q - OutW'(instr_rvalid_o);

  assign instr_gnt_o = instr_req_i && !fifo_empty && !flush_i &&
                       (outstanding_eff < OutW'(MaxOutstanding));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (instr_gnt_o && !instr_rvalid_o) begin
      outstanding_q <= outstanding_q + OutW'(1);
    end else if (!instr_gnt_o && instr_rvalid_o) begin
      outstanding_q <= outstanding_q - OutW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline
  // --------------------------------------------------------------------------
  // One stage per cycle of latency; the last stage drives the response bus.
  // Data registers only load when a valid entry moves in, so the last stage
  // naturally holds the most recent response word while rvalid is low.
  // The counted bit is cleared by a flush so in-flight responses still
  // complete on the bus but do not bump the freshly zeroed counter.
  logic [RespLatency-1:0] pipe_valid_q;
  logic [RespLatency-1:0] pipe_counted_q;
  logic [31:0]            pipe_data_q [RespLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_q   <= '0;
      pipe_counted_q <= '0;
      for (int i = 0; i < int'(RespLatency); i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0]   <= instr_gnt_o;
      pipe_counted_q[0] <= instr_gnt_o;
      if (instr_gnt_o) begin
        pipe_data_q[0] <= fifo_head;
      end
      for (int i = 1; i < int'(RespLatency); i++) begin
        pipe_valid_q[i]   <= pipe_valid_q[i-1];
        pipe_counted_q[i] <= pipe_counted_q[i-1] && !flush_i;
        if (pipe_valid_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
        end
      end
    end
  end

  assign instr_rvalid_o     = pipe_valid_q[RespLatency-1];
  assign instr_rdata_o      = pipe_data_q[RespLatency-1];
  assign instr_rdata_intg_o = secded_inv_39_32_intg(instr_rdata_o);
  assign instr_err_o        = 1'b0;

  // --------------------------------------------------------------------------
  // Response counter
  // --------------------------------------------------------------------------
  logic [31:0] resp_count_q;
  logic        resp_counted;

  assign resp_counted = instr_rvalid_o && pipe_counted_q[RespLatency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_count_q <= '0;
    end else if (flush_i) begin
      resp_count_q <= '0;
    end else if (resp_counted) begin
      resp_count_q <= resp_count_q + 32'd1;
    end
  end

  assign resp_count_o = resp_count_q;

  logic unused_addr;
  assign unused_addr = ^instr_addr_i;

  // --------------------------------------------------------------------------
  // Protocol assertions
  // --------------------------------------------------------------------------
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_o |-> (outstanding_q != '0));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= OutW'(MaxOutstanding));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_push |-> dii_ready_o);

endmodule

// File: tb/tb_testrig_dii_instr_feeder.sv
// ----------------------------------------------------------------------------
// tb_testrig_dii_instr_feeder
//
// Drives two feeders with identical stimulus: one at RespLatency=1 and one at
// RespLatency=3, both with a 4-entry FIFO and two outstanding fetches. A
// list-based reference model (pending words, in-flight responses with due
// cycles) predicts every output of both instances on each falling edge.
// Directed scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_testrig_dii_instr_feeder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dii_valid;
  logic [31:0] dii_insn;
  logic        instr_req;
  logic [31:0] instr_addr;

  logic        rdy0, gnt0, rv0, err0;
  logic [31:0] rd0, cnt0;
  logic [6:0]  intg0;
  logic        rdy1, gnt1, rv1, err1;
  logic [31:0] rd1, cnt1;
  logic [6:0]  intg1;

  int checks;
  int errors;
  int cyc;

  testrig_dii_instr_feeder #(
    .FifoDepth(4), .RespLatency(1), .MaxOutstanding(2)
  ) dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .dii_valid_i(dii_valid), .dii_insn_i(dii_insn), .dii_ready_o(rdy0),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(gnt0),
    .instr_rvalid_o(rv0), .instr_rdata_o(rd0), .instr_rdata_intg_o(intg0),
    .instr_err_o(err0), .resp_count_o(cnt0)
  );

  testrig_dii_instr_feeder #(
    .FifoDepth(4), .RespLatency(3), .MaxOutstanding(2)
  ) dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .dii_valid_i(dii_valid), .dii_insn_i(dii_insn), .dii_ready_o(rdy1),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(gnt1),
    .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .instr_rdata_intg_o(intg1),
    .instr_err_o(err1), .resp_count_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitwise form of the inverted SECDED(39,32) encoder's check columns.
  function automatic logic [6:0] enc_intg(input logic [31:0] d);
    logic [31:0] masks [7];
    logic [6:0]  p;
    masks[0] = 32'h2606BD25;
    masks[1] = 32'hDEBA8050;
    masks[2] = 32'h413D89AA;
    masks[3] = 32'h31234ED1;
    masks[4] = 32'hC2C1323B;
    masks[5] = 32'h2DCC624C;
    masks[6] = 32'h98505586;
    p = '0;
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 32; i++) begin
        if (masks[b][i]) p[b] = p[b] ^ d[i];
      end
    end
    return p ^ 7'b0101010;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model state, one slot per instance.
  int          lat [2];
  int          fifo_n [2];
  logic [31:0] fifo_q [2][8];
  int          fl_n [2];
  logic [31:0] fl_data [2][8];
  int          fl_due [2][8];
  bit          fl_cnt [2][8];
  logic [31:0] last_rd [2];
  logic [31:0] m_cnt [2];

  initial begin
    lat[0] = 1;
    lat[1] = 3;
  end

  task automatic model_step(input int k, input logic a_rdy, input logic a_gnt,
                            input logic a_rv, input logic [31:0] a_rd,
                            input logic [6:0] a_intg, input logic a_err,
                            input logic [31:0] a_cnt);
    bit          e_rv, e_gnt, e_rdy;
    logic [31:0] e_rd;
    string       tag;
    tag = (k == 0) ? "L1" : "L3";
    if (!rst_n) begin
      fifo_n[k]  = 0;
      fl_n[k]    = 0;
      last_rd[k] = '0;
      m_cnt[k]   = '0;
      check_output({tag, "_rst_ready"}, a_rdy, 1);
      check_output({tag, "_rst_gnt"}, a_gnt, 0);
      check_output({tag, "_rst_rvalid"}, a_rv, 0);
      check_output({tag, "_rst_rdata"}, a_rd, 0);
      check_output({tag, "_rst_intg"}, a_intg, enc_intg(32'h0));
      check_output({tag, "_rst_err"}, a_err, 0);
      check_output({tag, "_rst_count"}, a_cnt, 0);
      return;
    end
    e_rv  = (fl_n[k] > 0) && (fl_due[k][0] == cyc);
    e_rd  = e_rv ? fl_data[k][0] : last_rd[k];
    e_rdy = (fifo_n[k] < 4);
    e_gnt = instr_req && (fifo_n[k] > 0) && !flush && ((fl_n[k] - int'(e_rv)) < 2);
    check_output({tag, "_ready"}, a_rdy, e_rdy);
    check_output({tag, "_gnt"}, a_gnt, e_gnt);
    check_output({tag, "_rvalid"}, a_rv, e_rv);
    check_output({tag, "_rdata"}, a_rd, e_rd);
    check_output({tag, "_intg"}, a_intg, enc_intg(e_rd));
    check_output({tag, "_err"}, a_err, 0);
    check_output({tag, "_count"}, a_cnt, m_cnt[k]);

    if (e_rv) begin
      if (fl_cnt[k][0]) m_cnt[k] = m_cnt[k] + 1;
      last_rd[k] = fl_data[k][0];
      for (int i = 1; i < fl_n[k]; i++) begin
        fl_data[k][i-1] = fl_data[k][i];
        fl_due[k][i-1]  = fl_due[k][i];
        fl_cnt[k][i-1]  = fl_cnt[k][i];
      end
      fl_n[k]--;
    end
    if (flush) begin
      m_cnt[k]  = '0;
      fifo_n[k] = 0;
      for (int i = 0; i < fl_n[k]; i++) fl_cnt[k][i] = 1'b0;
    end else begin
      if (e_gnt) begin
        fl_data[k][fl_n[k]] = fifo_q[k][0];
        fl_due[k][fl_n[k]]  = cyc + lat[k];
        fl_cnt[k][fl_n[k]]  = 1'b1;
        fl_n[k]++;
        for (int i = 1; i < fifo_n[k]; i++) fifo_q[k][i-1] = fifo_q[k][i];
        fifo_n[k]--;
      end
      if (dii_valid && e_rdy) begin
        fifo_q[k][fifo_n[k]] = dii_insn;
        fifo_n[k]++;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    model_step(0, rdy0, gnt0, rv0, rd0, intg0, err0, cnt0);
    model_step(1, rdy1, gnt1, rv1, rd1, intg1, err1, cnt1);
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] insn,
                                input logic req, input logic fl);
    @(posedge clk);
    #1;
    dii_valid  = v;
    dii_insn   = insn;
    instr_req  = req;
    flush      = fl;
    instr_addr = instr_addr + 32'd4;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    dii_valid = 1'b0;
    dii_insn = '0;
    instr_req = 1'b0;
    instr_addr = 32'h8000_0000;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ready", rdy0, 1);
    check_output("reset_intg_zero", intg0, 7'h2A);
    check_output("reset_count", cnt1, 0);
    rst_n = 1'b1;

    // Two words, request held.
    apply_stimulus(1'b1, 32'h0000_0013, 1'b1, 1'b0); settle();
    check_output("t1_gnt_empty", gnt0, 0);
    apply_stimulus(1'b1, 32'h0010_0093, 1'b1, 1'b0); settle();
    check_output("t1_gnt_first_l1", gnt0, 1);
    check_output("t1_gnt_first_l3", gnt1, 1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t1_gnt_second", gnt0, 1);
    check_output("t1_rvalid_first", rv0, 1);
    check_output("t1_rdata_first", rd0, 32'h0000_0013);
    check_output("t1_intg_first", intg0, 7'h7D);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t1_gnt_drained", gnt0, 0);
    check_output("t1_rvalid_second", rv0, 1);
    check_output("t1_rdata_second", rd0, 32'h0010_0093);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0); settle();
    check_output("t1_rvalid_low", rv0, 0);
    check_output("t1_rdata_hold", rd0, 32'h0010_0093);
    check_output("t1_count_l1", cnt0, 2);
    check_output("t1_rvalid_l3", rv1, 1);
    check_output("t1_rdata_l3", rd1, 32'h0000_0013);
    idle(3); settle();
    check_output("t1_count_l3", cnt1, 2);

    // Fill the FIFO; a held push waits until a grant frees an entry.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h100 + i, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b0); settle();
    check_output("t2_full_l1", rdy0, 0);
    check_output("t2_full_l3", rdy1, 0);
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b0); settle();
    check_output("t2_full_held", rdy0, 0);
    apply_stimulus(1'b1, 32'h104, 1'b1, 1'b0); settle();
    check_output("t2_gnt_full", gnt0, 1);
    check_output("t2_no_bypass", rdy0, 0);
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b0); settle();
    check_output("t2_ready_after_pop", rdy0, 1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0); settle();
    check_output("t2_full_again", rdy0, 0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    idle(4); settle();
    check_output("t2_last_l1", rd0, 32'h104);
    check_output("t2_last_l3", rd1, 32'h104);
    check_output("t2_count_l1", cnt0, 7);
    check_output("t2_count_l3", cnt1, 7);

    // Outstanding limit with three-cycle latency.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h200 + i, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t3_gnt_c0", gnt1, 1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t3_gnt_c1", gnt1, 1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t3_stall_c2", gnt1, 0);
    check_output("t3_no_rvalid_c2", rv1, 0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t3_rvalid_c3", rv1, 1);
    check_output("t3_rdata_c3", rd1, 32'h200);
    check_output("t3_gnt_c3", gnt1, 1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    idle(4); settle();
    check_output("t3_count_l3", cnt1, 11);
    check_output("t3_last_l3", rd1, 32'h203);
    check_output("t3_count_l1", cnt0, 11);

    // Request against an empty FIFO simply waits.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
      check_output("t4_empty_gnt_l1", gnt0, 0);
      check_output("t4_empty_gnt_l3", gnt1, 0);
    end
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0); settle();
    check_output("t4_gnt_push_cycle", gnt0, 0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t4_gnt_next", gnt0, 1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0); settle();
    check_output("t4_rvalid", rv0, 1);
    check_output("t4_rdata", rd0, 32'hDEAD_BEEF);
    check_output("t4_intg", intg0, enc_intg(32'hDEAD_BEEF));
    idle(4); settle();
    check_output("t4_count_l1", cnt0, 12);

    // Flush with three words buffered and one fetch in flight.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h300 + i, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t5_gnt_l1", gnt0, 1);
    check_output("t5_gnt_l3", gnt1, 1);
    apply_stimulus(1'b1, 32'hBAD, 1'b1, 1'b1); settle();
    check_output("t5_inflight_rvalid", rv0, 1);
    check_output("t5_inflight_rdata", rd0, 32'h300);
    check_output("t5_gnt_flush", gnt0, 0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t5_gnt_after_l1", gnt0, 0);
    check_output("t5_gnt_after_l3", gnt1, 0);
    check_output("t5_count_l1", cnt0, 0);
    check_output("t5_count_l3", cnt1, 0);
    check_output("t5_ready", rdy0, 1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t5_inflight_l3", rv1, 1);
    check_output("t5_inflight_data_l3", rd1, 32'h300);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t5_uncounted_l3", cnt1, 0);
    apply_stimulus(1'b1, 32'h400, 1'b1, 1'b0); settle();
    check_output("t5_push_cycle_gnt", gnt0, 0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0); settle();
    check_output("t5_new_gnt_l1", gnt0, 1);
    check_output("t5_new_gnt_l3", gnt1, 1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0); settle();
    check_output("t5_new_rdata", rd0, 32'h400);
    idle(4); settle();
    check_output("t5_recount_l1", cnt0, 1);
    check_output("t5_recount_l3", cnt1, 1);

    // Asynchronous reset with two fetches outstanding.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h500 + i, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_output("t6_async_rvalid_l1", rv0, 0);
    check_output("t6_async_rvalid_l3", rv1, 0);
    check_output("t6_async_rdata", rd0, 0);
    check_output("t6_async_intg", intg1, 7'h2A);
    check_output("t6_async_count", cnt0, 0);
    check_output("t6_async_ready", rdy0, 1);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0); settle();
      check_output("t6_no_rvalid_l3", rv1, 0);
    end
    check_output("t6_count_l3", cnt1, 0);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
